// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: stream-to-RAM FIFO controller for a 16x8 dual-port RAM with
// registered read. Incoming words are written into the RAM as a circular
// buffer; reads are issued on a credit basis so the returned data always
// fits into a 2-entry output buffer that drives the output stream.
// Optional feature macro: RAM_FIFO_CTRL_ALMOST_FULL_EN adds parameter
// AF_THRESH and a registered almost_full output.
module ram_fifo_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
`ifdef RAM_FIFO_CTRL_ALMOST_FULL_EN
  ,
  parameter int AF_THRESH = (2**ADDR_W) - 2
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              wr_enb,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_enb,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   count
`ifdef RAM_FIFO_CTRL_ALMOST_FULL_EN
  ,
  output logic              almost_full
`endif
);

  // Resident-word count that means "RAM full": only the wrap bit set.
  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);

  logic [ADDR_W:0]   wptr_reg, rptr_reg;
  logic [ADDR_W:0]   wptr_next, rptr_next;
  logic [ADDR_W:0]   ram_cnt;
  logic              inflight_reg;
  logic [1:0]        obuf_cnt_reg;
  logic              obuf_head_reg;
  logic [DATA_W-1:0] obuf_mem [2];
  logic              obuf_wr_idx;
  logic              pop;
  logic              push;
  logic [2:0]        obuf_occ;
  logic [2:0]        obuf_limit;

  // Pointers carry an extra wrap bit so full (16) and empty (0) differ.
  assign ram_cnt = wptr_reg - rptr_reg;

  // Write side: accept whenever the RAM has a free slot.
  assign in_ready = !rst && (ram_cnt != FULL_CNT);
  assign wr_enb   = in_valid && in_ready;
  assign wr_addr  = rst ? '0 : wptr_reg[ADDR_W-1:0];
  assign wr_data  = rst ? '0 : in_data;

  // Output side: head of the 2-entry buffer.
  assign out_valid = !rst && (obuf_cnt_reg != 2'd0);
  assign out_data  = obuf_mem[obuf_head_reg];
  assign pop       = out_valid && out_ready;
  assign push      = inflight_reg;

  // Credit check: buffered + in-flight words, less this cycle's pop, must
  // leave room for one more returned word. Written as occ < 2 + pop to stay
  // in unsigned arithmetic.
  assign obuf_occ   = {1'b0, obuf_cnt_reg} + {2'b00, inflight_reg};
  assign obuf_limit = 3'd2 + {2'b00, pop};
  assign rd_enb     = !rst && (ram_cnt != '0) && (obuf_occ < obuf_limit);
  assign rd_addr    = rst ? '0 : rptr_reg[ADDR_W-1:0];

  assign count = rst ? '0 : ram_cnt;

  assign wptr_next = wr_enb ? (wptr_reg + PTR_ONE) : wptr_reg;
  assign rptr_next = rd_enb ? (rptr_reg + PTR_ONE) : rptr_reg;

  // Tail slot of the output buffer: head plus occupancy, modulo 2.
  assign obuf_wr_idx = obuf_head_reg ^ obuf_cnt_reg[0];

  // RAM pointers and the read-in-flight flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_reg     <= '0;
      rptr_reg     <= '0;
      inflight_reg <= 1'b0;
    end else begin
      wptr_reg     <= wptr_next;
      rptr_reg     <= rptr_next;
      inflight_reg <= rd_enb;
    end
  end

  // Output buffer occupancy and head; push+pop keeps the count and rotates.
  always_ff @(posedge clk) begin
    if (rst) begin
      obuf_cnt_reg  <= 2'd0;
      obuf_head_reg <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10:   obuf_cnt_reg <= obuf_cnt_reg + 2'd1;
        2'b01: begin
          obuf_cnt_reg  <= obuf_cnt_reg - 2'd1;
          obuf_head_reg <= ~obuf_head_reg;
        end
        2'b11:   obuf_head_reg <= ~obuf_head_reg;
        default: ;
      endcase
    end
  end

  // Capture returned RAM data into the tail slot; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      obuf_mem[obuf_wr_idx] <= rd_data;
    end
  end

`ifdef RAM_FIFO_CTRL_ALMOST_FULL_EN
  logic [ADDR_W:0] ram_cnt_next;
  assign ram_cnt_next = wptr_next - rptr_next;

  // Registered threshold flag, aligned with the count it describes.
  always_ff @(posedge clk) begin
    if (rst) begin
      almost_full <= 1'b0;
    end else begin
      almost_full <= (int'(ram_cnt_next) >= AF_THRESH);
    end
  end
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: self-checking bench for ram_fifo_ctrl. A behavioural
// RAM model serves the DUT's read/write ports; a queue-based reference model
// (RAM contents, in-flight word, output buffer) predicts every output.
module tb_ram_fifo_ctrl;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              wr_enb;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_enb;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data = '0;
  logic [ADDR_W:0]   count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ram_fifo_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_enb(rd_enb), .rd_addr(rd_addr), .rd_data(rd_data),
    .count(count)
  );

  // Behavioural 16x8 dual-port RAM with registered read.
  logic [DATA_W-1:0] ram_mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) ram_mem[i] = '0;
  always @(posedge clk) begin
    if (wr_enb) ram_mem[wr_addr] <= wr_data;
    if (rd_enb) rd_data <= ram_mem[rd_addr];
  end

  // One line per delivered output word.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) $display("tb: out word %02h at %0t", out_data, $time);
  end

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] m_ram[$];
  logic [DATA_W-1:0] m_infl[$];
  logic [DATA_W-1:0] m_obuf[$];
  int m_wcnt = 0;
  int m_rcnt = 0;

  logic              e_in_ready, e_wr, e_rd, e_out_valid, e_pop;
  logic [DATA_W-1:0] e_out_data, e_in_data;
  logic [ADDR_W-1:0] e_wr_addr, e_rd_addr;
  logic [ADDR_W:0]   e_count;

  task automatic model_eval();
    e_in_data = in_data;
    if (rst) begin
      e_in_ready = 0; e_wr = 0; e_rd = 0; e_out_valid = 0; e_pop = 0;
      e_out_data = '0; e_wr_addr = '0; e_rd_addr = '0; e_count = '0;
    end else begin
      e_count     = (ADDR_W+1)'(m_ram.size());
      e_in_ready  = (m_ram.size() != DEPTH);
      e_wr        = in_valid && e_in_ready;
      e_out_valid = (m_obuf.size() != 0);
      e_out_data  = (m_obuf.size() != 0) ? m_obuf[0] : '0;
      e_pop       = e_out_valid && out_ready;
      e_rd        = (m_ram.size() != 0) &&
                    (m_obuf.size() + m_infl.size() - (e_pop ? 1 : 0) < 2);
      e_wr_addr   = ADDR_W'(m_wcnt % DEPTH);
      e_rd_addr   = ADDR_W'(m_rcnt % DEPTH);
    end
  endtask

  task automatic model_advance();
    if (rst) begin
      m_ram.delete(); m_infl.delete(); m_obuf.delete();
      m_wcnt = 0; m_rcnt = 0;
    end else begin
      if (e_pop) void'(m_obuf.pop_front());
      if (m_infl.size() != 0) m_obuf.push_back(m_infl.pop_front());
      if (e_rd) begin m_infl.push_back(m_ram.pop_front()); m_rcnt++; end
      if (e_wr) begin m_ram.push_back(e_in_data); m_wcnt++; end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1; in_valid = 1; in_data = 8'h5A; out_ready = 1;
    for (int c = 0; c < 3; c++) begin
      sample();
      n_checks++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
      n_checks++; if (wr_enb !== 1'b0)    begin n_fail++; $display("FAIL reset_wr_enb got=%0b exp=0", wr_enb); end
      n_checks++; if (rd_enb !== 1'b0)    begin n_fail++; $display("FAIL reset_rd_enb got=%0b exp=0", rd_enb); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
      n_checks++; if (count !== 5'd0)     begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
      advance();
    end
    rst = 0; in_valid = 0;
  endtask

  task automatic test_single_word();
    out_ready = 1; in_data = 8'hA5;
    for (int c = 0; c < 6; c++) begin
      in_valid = (c == 0);
      sample();
      if (c == 0) begin
        n_checks++; if (wr_enb !== 1'b1 || wr_addr !== 4'd0) begin n_fail++; $display("FAIL single_wr got=%0b/%0d exp=1/0", wr_enb, wr_addr); end
      end
      if (c == 1) begin
        n_checks++; if (rd_enb !== 1'b1 || rd_addr !== 4'd0) begin n_fail++; $display("FAIL single_rd got=%0b/%0d exp=1/0", rd_enb, rd_addr); end
      end
      n_checks++; if (out_valid !== (c == 3)) begin n_fail++; $display("FAIL single_out_valid c=%0d got=%0b exp=%0b", c, out_valid, (c == 3)); end
      if (c == 3) begin
        n_checks++; if (out_data !== 8'hA5) begin n_fail++; $display("FAIL single_out_data got=%02h exp=a5", out_data); end
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    int idx = 0;
    int acc = 0;
    out_ready = 0;
    for (int c = 0; c < 30; c++) begin
      in_valid = (idx < 20); in_data = DATA_W'(idx);
      sample();
      n_checks++; if (wr_enb !== e_wr)     begin n_fail++; $display("FAIL bp_wr_enb c=%0d got=%0b exp=%0b", c, wr_enb, e_wr); end
      n_checks++; if (count !== e_count)   begin n_fail++; $display("FAIL bp_count c=%0d got=%0d exp=%0d", c, count, e_count); end
      if (wr_enb) acc++;
      if (e_wr) idx++;
      advance();
    end
    sample();
    n_checks++; if (acc != 18)           begin n_fail++; $display("FAIL bp_accepted got=%0d exp=18", acc); end
    n_checks++; if (in_ready !== 1'b0)   begin n_fail++; $display("FAIL bp_in_ready got=%0b exp=0", in_ready); end
    n_checks++; if (count !== 5'd16)     begin n_fail++; $display("FAIL bp_full_count got=%0d exp=16", count); end
    n_checks++; if (out_data !== 8'h00)  begin n_fail++; $display("FAIL bp_head got=%02h exp=00", out_data); end
    advance();
    in_valid = 0; out_ready = 1;
    for (int k = 0; k < 18; k++) begin
      sample();
      n_checks++; if (out_valid !== 1'b1 || out_data !== DATA_W'(k)) begin n_fail++; $display("FAIL bp_drain k=%0d got=%0b/%02h exp=1/%02h", k, out_valid, out_data, k); end
      advance();
    end
    sample();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained got=%0b exp=0", out_valid); end
    advance();
  endtask

  task automatic test_wrap_around();
    int wraps_w = 0;
    int wraps_r = 0;
    logic [ADDR_W-1:0] last_w = '0;
    logic [ADDR_W-1:0] last_r = '0;
    rst = 1; sample(); advance(); rst = 0;
    out_ready = 1;
    for (int c = 0; c < 46; c++) begin
      in_valid = (c < 40); in_data = DATA_W'(8'h30 + c);
      sample();
      n_checks++; if (wr_enb !== (c < 40)) begin n_fail++; $display("FAIL wrap_wr_enb c=%0d got=%0b exp=%0b", c, wr_enb, (c < 40)); end
      if (wr_enb) begin
        n_checks++; if (wr_addr !== e_wr_addr) begin n_fail++; $display("FAIL wrap_wr_addr c=%0d got=%0d exp=%0d", c, wr_addr, e_wr_addr); end
        if (last_w == 4'd15 && wr_addr == 4'd0) wraps_w++;
        last_w = wr_addr;
      end
      if (rd_enb) begin
        n_checks++; if (rd_addr !== e_rd_addr) begin n_fail++; $display("FAIL wrap_rd_addr c=%0d got=%0d exp=%0d", c, rd_addr, e_rd_addr); end
        if (last_r == 4'd15 && rd_addr == 4'd0) wraps_r++;
        last_r = rd_addr;
      end
      if (c >= 3 && c < 43) begin
        n_checks++; if (out_valid !== 1'b1 || out_data !== DATA_W'(8'h30 + c - 3)) begin n_fail++; $display("FAIL wrap_out c=%0d got=%0b/%02h exp=1/%02h", c, out_valid, out_data, 8'h30 + c - 3); end
      end else begin
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_idle c=%0d got=%0b exp=0", c, out_valid); end
      end
      advance();
    end
    n_checks++; if (wraps_w != 2 || wraps_r != 2) begin n_fail++; $display("FAIL wrap_count got=%0d/%0d exp=2/2", wraps_w, wraps_r); end
  endtask

  task automatic test_full_boundary();
    logic prev_rd = 0;
    logic prev_ir = 1;
    int reasserts = 0;
    out_ready = 0; in_valid = 1;
    for (int c = 0; c < 25; c++) begin
      in_data = DATA_W'($urandom);
      sample(); advance();
    end
    for (int c = 0; c < 24; c++) begin
      out_ready = (c % 2 == 0); in_data = DATA_W'($urandom);
      sample();
      n_checks++; if (in_ready !== e_in_ready) begin n_fail++; $display("FAIL full_in_ready c=%0d got=%0b exp=%0b", c, in_ready, e_in_ready); end
      n_checks++; if (rd_enb !== e_rd)         begin n_fail++; $display("FAIL full_rd_enb c=%0d got=%0b exp=%0b", c, rd_enb, e_rd); end
      n_checks++; if (count > 5'd16 || count !== e_count) begin n_fail++; $display("FAIL full_count c=%0d got=%0d exp=%0d", c, count, e_count); end
      n_checks++; if (out_valid && out_data !== e_out_data) begin n_fail++; $display("FAIL full_out_data c=%0d got=%02h exp=%02h", c, out_data, e_out_data); end
      if (prev_rd && !prev_ir) begin
        reasserts++;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_reassert c=%0d got=%0b exp=1", c, in_ready); end
      end
      prev_rd = rd_enb; prev_ir = in_ready;
      advance();
    end
    n_checks++; if (reasserts < 5) begin n_fail++; $display("FAIL full_reassert_seen got=%0d exp>=5", reasserts); end
  endtask

  task automatic test_reset_mid_stream();
    logic seen = 0;
    rst = 1; in_valid = 0; out_ready = 0; sample(); advance(); rst = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1; in_data = DATA_W'(8'h80 + c);
      sample(); advance();
    end
    in_valid = 0; out_ready = 1;
    sample();
    n_checks++; if (count !== 5'd6 || rd_enb !== 1'b1) begin n_fail++; $display("FAIL mid_pre got=%0d/%0b exp=6/1", count, rd_enb); end
    advance();
    rst = 1; out_ready = 0;
    sample();
    n_checks++; if (out_valid !== 1'b0 || count !== 5'd0) begin n_fail++; $display("FAIL mid_during got=%0b/%0d exp=0/0", out_valid, count); end
    advance();
    rst = 0; in_valid = 1; in_data = 8'h77; out_ready = 1;
    sample();
    n_checks++; if (out_valid !== 1'b0 || count !== 5'd0) begin n_fail++; $display("FAIL mid_after got=%0b/%0d exp=0/0", out_valid, count); end
    n_checks++; if (wr_enb !== 1'b1 || wr_addr !== 4'd0) begin n_fail++; $display("FAIL mid_push got=%0b/%0d exp=1/0", wr_enb, wr_addr); end
    advance();
    in_valid = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      sample();
      if (out_valid) begin
        seen = 1;
        n_checks++; if (out_data !== 8'h77) begin n_fail++; $display("FAIL mid_first got=%02h exp=77", out_data); end
      end
      advance();
    end
    if (!seen) begin n_checks++; n_fail++; $display("FAIL mid_timeout got=no_output exp=77"); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      rst       = ($urandom_range(0, 149) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = DATA_W'($urandom);
      out_ready = ((c / 100) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      sample();
      n_checks++; if (in_ready !== e_in_ready)   begin n_fail++; $display("FAIL rnd_in_ready c=%0d got=%0b exp=%0b", c, in_ready, e_in_ready); end
      n_checks++; if (wr_enb !== e_wr)           begin n_fail++; $display("FAIL rnd_wr_enb c=%0d got=%0b exp=%0b", c, wr_enb, e_wr); end
      n_checks++; if (rd_enb !== e_rd)           begin n_fail++; $display("FAIL rnd_rd_enb c=%0d got=%0b exp=%0b", c, rd_enb, e_rd); end
      n_checks++; if (out_valid !== e_out_valid) begin n_fail++; $display("FAIL rnd_out_valid c=%0d got=%0b exp=%0b", c, out_valid, e_out_valid); end
      n_checks++; if (count !== e_count)         begin n_fail++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, count, e_count); end
      n_checks++; if (wr_addr !== e_wr_addr)     begin n_fail++; $display("FAIL rnd_wr_addr c=%0d got=%0d exp=%0d", c, wr_addr, e_wr_addr); end
      n_checks++; if (rd_addr !== e_rd_addr)     begin n_fail++; $display("FAIL rnd_rd_addr c=%0d got=%0d exp=%0d", c, rd_addr, e_rd_addr); end
      if (e_wr) begin
        n_checks++; if (wr_data !== e_in_data)   begin n_fail++; $display("FAIL rnd_wr_data c=%0d got=%02h exp=%02h", c, wr_data, e_in_data); end
      end
      if (e_out_valid) begin
        n_checks++; if (out_data !== e_out_data) begin n_fail++; $display("FAIL rnd_out_data c=%0d got=%02h exp=%02h", c, out_data, e_out_data); end
      end
      advance();
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_backpressure();
    test_wrap_around();
    test_full_boundary();
    test_reset_mid_stream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
